uart_rx_ctrl_module: RTL

//  UART receive controller: detects the start-bit falling edge on the RX pin and sequences one frame.

---
 rtl/uart_rx_ctrl_module_pkg.sv | 14 +
 rtl/uart_rx_ctrl_module_htl.sv | 19 +
 rtl/uart_rx_ctrl_module.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_module_pkg.sv
// uart_rx_ctrl_module_pkg: receiver state encoding and baud timing constants.
package uart_rx_ctrl_module_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD = 115200;
  function automatic int bps_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
  function automatic int half_bit(input int bps);
    return bps / 2;
  endfunction
  localparam int DEF_BPS_CNT = bps_cnt(DEF_CLK_FREQ, DEF_BAUD);
  localparam int DEF_HALF_BIT = half_bit(DEF_BPS_CNT);
endpackage

// File: rtl/uart_rx_ctrl_module_htl.sv
// HtL_detect_module: falling-edge detector on an already synchronised line.
module HtL_detect_module (
  input  logic CLK,
  input  logic RSTn,
  input  logic sig_i,
  output logic h2l_o
);
  logic f1_q, f2_q;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      f1_q <= 1'b1;
      f2_q <= 1'b1;
    end else begin
      f1_q <= sig_i;
      f2_q <= f1_q;
    end
  end
  assign h2l_o = f2_q & ~f1_q;
endmodule

// File: rtl/uart_rx_ctrl_module.sv
// uart_rx_ctrl_module: UART frame receiver with optional parity and framing/break handling.
module uart_rx_ctrl_module
  import uart_rx_ctrl_module_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD = DEF_BAUD,
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 Rx_Pin_In,
  input  logic                 Rx_En,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Done,
  output logic                 Rx_Err,
  output logic                 Rx_Busy
);
  localparam int BPS = bps_cnt(CLK_FREQ, BAUD);
  localparam int HALF = half_bit(BPS);
  localparam int CW = $clog2(BPS);
  localparam int BW = $clog2(DATA_BITS);
  rx_state_e state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic par_err_q, par_err_d, done_q, done_d, err_q, err_d;
  logic h2l, line, mid;
  HtL_detect_module u_htl (
    .CLK  (CLK),
    .RSTn (RSTn),
    .sig_i(sync_q[1]),
    .h2l_o(h2l)
  );
  assign line = sync_q[1];
  assign mid = cnt_q == CW'(HALF);
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || state_q == BREAK) ? '0 : (cnt_q == CW'(BPS - 1) ? '0 : cnt_q + 1'b1);
    bit_d = bit_q;
    shift_d = shift_q;
    par_err_d = par_err_q;
    data_d = data_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (state_q != IDLE && !Rx_En) begin
      state_d = IDLE;
      cnt_d = '0;
      bit_d = '0;
    end else begin
      case (state_q)
        IDLE: if (h2l && Rx_En) begin
          state_d = START;
          cnt_d = '0;
          bit_d = '0;
          par_err_d = 1'b0;
        end
        START: if (mid) state_d = line ? IDLE : DATA;
        DATA: if (mid) begin
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: if (mid) begin
          par_err_d = line != (^shift_q ^ (PARITY_ODD != 0));
          state_d = STOP;
        end
        // A low stop bit is a break or framing fault: wait for the line to recover.
        STOP: if (mid) begin
          if (!line) begin
            err_d = 1'b1;
            state_d = BREAK;
          end else if (par_err_q) begin
            err_d = 1'b1;
            state_d = IDLE;
          end else begin
            data_d = shift_q;
            done_d = 1'b1;
            state_d = IDLE;
          end
        end
        BREAK: if (line) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      sync_q <= 2'b11;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_err_q <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], Rx_Pin_In};
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_err_q <= par_err_d;
      data_q <= data_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign Rx_Data = data_q;
  assign Rx_Done = done_q;
  assign Rx_Err = err_q;
  assign Rx_Busy = state_q != IDLE;
endmodule
